dense_fc_engine: RTL and testbench

//  Parametrised fully-connected layer engine; successor to the fixed 16-channel, 13x13 dense stage.

---
 rtl/dense_fc_engine_if.sv | 32 +++
 rtl/dense_fc_engine.sv | 140 ++++++++++++++
 tb/tb_dense_fc_engine.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dense_fc_engine_if.sv
// rtl/dense_fc_engine_if.sv - control, memory and result-stream bundle for dense_fc_engine.
interface dense_fc_engine_if #(
  parameter int ADDR_W = 3,
  parameter int D_W    = 8,
  parameter int W_W    = 8,
  parameter int NOUT   = 3,
  parameter int IDX_W  = 2,
  parameter int OUT_W  = 8
);
  logic                   start;
  logic                   relu_en;
  logic [ADDR_W-1:0]      act_addr;
  logic [D_W-1:0]         act_data;
  logic [ADDR_W-1:0]      wt_addr;
  logic [NOUT*W_W-1:0]    wt_data;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [IDX_W-1:0]       out_idx;
  logic [OUT_W-1:0]       out_data;
  logic                   done;

  modport master (
    input  start, relu_en, act_data, wt_data, out_ready,
    output act_addr, wt_addr, busy, out_valid, out_idx, out_data, done
  );

  modport slave (
    output start, relu_en, act_data, wt_data, out_ready,
    input  act_addr, wt_addr, busy, out_valid, out_idx, out_data, done
  );
endinterface

// File: rtl/dense_fc_engine.sv
// rtl/dense_fc_engine.sv - fully-connected layer engine: NOUT parallel MACs over an IN_CH x IN_H x IN_W buffer.
module dense_fc_engine #(
  parameter int IN_CH = 16,
  parameter int IN_H  = 13,
  parameter int IN_W  = 13,
  parameter int NOUT  = 10,
  parameter int D_W   = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  dense_fc_engine_if.master bus
);
  localparam int N      = IN_CH * IN_H * IN_W;
  localparam int ADDR_W = $clog2(N);
  localparam int IDX_W  = $clog2(NOUT);
  localparam int PROD_W = D_W + W_W;

  localparam logic [ADDR_W-1:0]      LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NOUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_EMIT} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      rd_valid_q, rd_valid_d;
  logic signed [ACC_W-1:0]   acc_q [NOUT];
  logic signed [ACC_W-1:0]   acc_d [NOUT];
  logic signed [PROD_W-1:0]  prod [NOUT];
  logic                      relu_q, relu_d;
  logic                      busy_q, busy_d;
  logic                      out_valid_q, out_valid_d;
  logic [IDX_W-1:0]          out_idx_q, out_idx_d;
  logic [OUT_W-1:0]          out_data_q, out_data_d;
  logic                      done_q, done_d;

  function automatic logic [OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] acc, input logic relu);
    logic signed [ACC_W-1:0] v;
    v = acc >>> SHIFT;
    if (relu && v[ACC_W-1]) v = '0;
    if (v > SAT_MAX) v = SAT_MAX;
    if (v < SAT_MIN) v = SAT_MIN;
    return OUT_W'(v);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_valid_d  = (state_q == S_FETCH);
    acc_d       = acc_q;
    relu_d      = relu_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    // Memory data trails the address by one cycle, so accumulate on the registered fetch flag.
    for (int n = 0; n < NOUT; n++) begin
      prod[n] = PROD_W'($signed(bus.act_data)) * PROD_W'($signed(bus.wt_data[n*W_W +: W_W]));
      if (rd_valid_q) acc_d[n] = acc_q[n] + ACC_W'(prod[n]);
    end

    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse belongs to the previous pass and is dropped.
        if (bus.start && !done_q) begin
          state_d = S_FETCH;
          addr_d  = '0;
          relu_d  = bus.relu_en;
          busy_d  = 1'b1;
          for (int n = 0; n < NOUT; n++) acc_d[n] = '0;
        end
      end
      S_FETCH: begin
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                     addr_d  = addr_q + 1'b1;
      end
      S_DRAIN: begin
        state_d     = S_EMIT;
        out_valid_d = 1'b1;
        out_idx_d   = '0;
        out_data_d  = post_proc(acc_d[0], relu_q);
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          if (out_idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            out_idx_d  = out_idx_q + 1'b1;
            out_data_d = post_proc(acc_q[out_idx_d], relu_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rd_valid_q  <= 1'b0;
      for (int n = 0; n < NOUT; n++) acc_q[n] <= '0;
      relu_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_valid_q  <= rd_valid_d;
      for (int n = 0; n < NOUT; n++) acc_q[n] <= acc_d[n];
      relu_q      <= relu_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign bus.act_addr  = addr_q;
  assign bus.wt_addr   = addr_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_dense_fc_engine.sv
// tb/tb_dense_fc_engine.sv - table-driven and scoreboarded bench for dense_fc_engine (2x2x2 input, 3 neurons).
module tb_dense_fc_engine;
  localparam int N    = 8;
  localparam int NOUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dense_fc_engine_if #(.ADDR_W(3), .D_W(8), .W_W(8), .NOUT(3), .IDX_W(2), .OUT_W(8)) bus ();

  dense_fc_engine #(
    .IN_CH(2), .IN_H(2), .IN_W(2), .NOUT(3), .D_W(8), .W_W(8),
    .ACC_W(24), .OUT_W(8), .SHIFT(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]  act_mem [N];
  logic [23:0] wt_mem  [N];

  always @(posedge clk) begin
    bus.act_data <= act_mem[bus.act_addr];
    bus.wt_data  <= wt_mem[bus.wt_addr];
  end

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int act;
    int w0, w1, w2;
    bit relu;
    int mode;
    int e0, e1, e2;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual_idx=%0d required=none", bus.out_idx);
      end else begin
        e = sb.pop_front();
        chk("out_idx", int'(bus.out_idx), int'(e.idx));
        chk("out_data", int'($signed(bus.out_data)), int'($signed(e.data)));
      end
    end
    if (rst && bus.done) done_cnt++;
  end

  function automatic int sat8(input int v, input bit relu);
    int r;
    r = v;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic fill_uniform(input int a, input int w0, input int w1, input int w2);
    for (int i = 0; i < N; i++) begin
      act_mem[i] = 8'(a);
      wt_mem[i]  = {8'(w2), 8'(w1), 8'(w0)};
    end
  endtask

  task automatic push_exp(input int n, input int v);
    exp_t e;
    e.idx  = 2'(n);
    e.data = 8'(v);
    sb.push_back(e);
  endtask

  task automatic push_model(input bit relu);
    int sum, a, w;
    logic [7:0] wb;
    for (int n = 0; n < NOUT; n++) begin
      sum = 0;
      for (int i = 0; i < N; i++) begin
        a   = int'($signed(act_mem[i]));
        wb  = wt_mem[i][n*8 +: 8];
        w   = int'($signed(wb));
        sum = sum + a * w;
      end
      push_exp(n, sat8(sum, relu));
    end
  endtask

  // mode 0: ready high; 1: stall 5 cycles on idx1; 2: random ready; 3: stray start pulses
  task automatic run_pass(input bit relu, input int mode);
    int cyc, d0, h0, stall;
    logic [7:0] cap;
    d0 = done_cnt;
    h0 = hs_cnt;
    stall = 0;
    cap = '0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.relu_en = relu;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.relu_en = ~relu;
    chk("busy_after_start", int'(bus.busy), 1);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      if (mode == 3) bus.start = (cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("first_valid_latency", cyc, 9);
    cyc = 0;
    while (done_cnt == d0 && cyc < 200) begin
      case (mode)
        1: begin
          if (bus.out_valid && bus.out_idx == 2'd1 && stall < 5) begin
            if (stall == 0) cap = bus.out_data;
            else chk("stall_data_stable", int'(bus.out_data), int'(cap));
            bus.out_ready = 1'b0;
            stall++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        2: bus.out_ready = 1'($urandom_range(0, 1));
        3: bus.start = (cyc == 1) || bus.done;
        default: bus.out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    if (mode == 1) chk("stall_cycles", stall, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("handshakes", hs_cnt - h0, NOUT);
    chk("busy_idle", int'(bus.busy), 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1,   2,   2,    2, 1'b0, 0, 16,  16,   16};
    vecs[1] = '{127, 127, -128, 0, 1'b0, 3, 127, -128, 0};
    vecs[2] = '{1,   2,   -3,   0, 1'b1, 0, 16,  0,    0};
    vecs[3] = '{1,   2,   -3,   0, 1'b0, 1, 16,  -24,  0};
    vecs[4] = '{-5,  3,   -3,   1, 1'b0, 2, -120, 120, -40};
    vecs[5] = '{-5,  3,   -3,   1, 1'b1, 0, 0,   120,  0};

    rst = 1'b0;
    bus.start = 1'b0;
    bus.relu_en = 1'b0;
    bus.out_ready = 1'b1;
    fill_uniform(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_act_addr", int'(bus.act_addr), 0);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      fill_uniform(vecs[v].act, vecs[v].w0, vecs[v].w1, vecs[v].w2);
      push_exp(0, vecs[v].e0);
      push_exp(1, vecs[v].e1);
      push_exp(2, vecs[v].e2);
      run_pass(vecs[v].relu, vecs[v].mode);
    end

    for (int i = 0; i < N; i++) begin
      act_mem[i] = 8'(i - 3);
      wt_mem[i]  = {8'd50, 8'(-i), 8'(2 * i + 1)};
    end
    push_model(1'b0);
    run_pass(1'b0, 2);

    begin
      int d0, h0;
      d0 = done_cnt;
      h0 = hs_cnt;
      fill_uniform(100, 100, 100, 100);
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("fetch_busy_before_reset", int'(bus.busy), 1);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_act_addr", int'(bus.act_addr), 0);
      repeat (15) @(posedge clk);
      #1;
      chk("midrst_no_output", hs_cnt - h0, 0);
      chk("midrst_no_done", done_cnt - d0, 0);
    end

    fill_uniform(1, 2, -3, 5);
    push_model(1'b0);
    run_pass(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
